xcorr_scheduler: RTL and testbench
==================================

Name: xcorr_scheduler

Overview:
- Frame-level sequencer for the microphone delay-estimation pipeline.
- Launches ADC captures into the ping-pong buffers and waits for the buffer swap.
- For each frame, runs xcorr and then argmax once per microphone pair: (ch0,ch1), (ch0,ch2), (ch0,ch3).
- Latches the per-pair peak lag indices and publishes them with a one-cycle valid. Sits between adc8x512/pingpong8x512 and xcorr/argmax in top.

Parameters:
- IDX_W, 9, width of argmax peak index and of the delay outputs.
- NPAIRS, 3, pairs processed per frame (legal 1..3); pair k is (ch0, ch(k+1)).
- CNT_W, 16, width of the frame counter.
- TIMEOUT, 65535, watchdog limit in cycles per wait state (used only with the optional feature).

Ports:
- clk  in  1  system clock.
- n_rst  in  1  reset, synchronous, active-low.
- enable  in  1  level; high = run frames continuously.
- sample_start  out  1  one-cycle pulse to the sampler start input.
- sample_done  in  1  sampler doneWriting; level, held high after a capture.
- buf_ready  in  1  AND of the pingpong goodToGo outputs.
- pair_sel  out  2  selects the ch(pair_sel+1) buffer onto the xcorr b port; stable throughout XCORR and ARGMAX.
- xcorr_start  out  1  one-cycle pulse to xcorr start.
- xcorr_done  in  1  xcorr valid; level.
- argmax_start  out  1  one-cycle pulse to argmax start.
- argmax_done  in  1  argmax valid; level.
- argmax_index  in  IDX_W  argmax maxIndex; sampled on the argmax_done rising edge.
- delay0, delay1, delay2  out  IDX_W each  latched peak index for pairs 0, 1, 2.
- result_valid  out  1  one-cycle pulse when all delays are updated for a frame.
- frame_count  out  CNT_W  completed frames; wraps to 0.
- busy  out  1  high in every state except IDLE.
- timeout_err  out  1  sticky watchdog error flag.

Behaviour:
- Reset (n_rst low at a clk edge) applies mid-operation as well:
  - state goes to IDLE and the capture-in-flight flag clears;
  - all pulse outputs are 0; pair_sel, delay0..2, frame_count and timeout_err are 0.
- Done detection:
  - Each done input is registered once (done_q).
  - A phase completes only on done & ~done_q, seen after that phase's start pulse.
  - A done level that is already high when the phase is entered is ignored until it falls and rises again.
- States:
  - IDLE: if enable, pulse sample_start, set inflight=1 -> FILL.
  - FILL: on sample_done rising edge -> SWAP.
  - SWAP: wait for buf_ready=1. On that cycle:
    - pair_sel=0 and pulse xcorr_start;
    - if enable, also pulse sample_start (next frame captures while this frame is processed), inflight=1; otherwise inflight=0;
    - -> XCORR.
  - XCORR: on xcorr_done rising edge, pulse argmax_start next cycle -> ARGMAX.
  - ARGMAX: on argmax_done rising edge, latch argmax_index into delay[pair_sel].
    - If pair_sel==NPAIRS-1 -> PUBLISH.
    - Else increment pair_sel, pulse xcorr_start -> XCORR.
  - PUBLISH (one cycle): pulse result_valid, frame_count+=1 with wrap; -> FILL if inflight, else IDLE.
- Latency:
  - sample_start to xcorr_start: 1 cycle after the later of the sample_done edge and buf_ready.
  - Final argmax_done edge to result_valid: 2 cycles.
- Delays for pairs >= NPAIRS are never written and stay 0.
- Dropping enable affects only whether the next capture is launched. The current frame always completes and publishes.
- A sample_done edge arriving while the scheduler is in XCORR/ARGMAX is remembered: FILL exits immediately on entry.
- Start pulses are never asserted in the same cycle as a state's exit condition for a different phase. At most one of xcorr_start/argmax_start is high per cycle.

Optional Feature:
- Macro: XCORR_SCHED_WATCHDOG_EN.
- When defined:
  - A wait counter clears on every state entry and increments in FILL/SWAP/XCORR/ARGMAX.
  - On reaching TIMEOUT: timeout_err=1 (sticky until reset), inflight=0, pair_sel=0, -> IDLE, no result_valid.
  - If enable is still high, the next frame restarts from IDLE.
- When not defined: no counter, timeout_err tied 0, all waits are unbounded.

Test Plan:
- Single frame, NPAIRS=3, enable pulsed high for 1 cycle; argmax model returns 100, 255, 3 -> one sample_start, three xcorr_start/argmax_start pairs with pair_sel 0,1,2; delay0/1/2=100/255/3; result_valid once; frame_count=1; busy low afterwards.
- Continuous run, enable held high for 4 frames -> sample_start issued at each SWAP; frame_count=4 after the fourth result_valid; pair_sel returns to 0 for each frame.
- sample_done already high on FILL entry (stale level) -> no SWAP until sample_done falls and rises; buf_ready held low for 50 cycles in SWAP -> xcorr_start exactly 1 cycle after buf_ready rises.
- n_rst low for 1 cycle while in ARGMAX with pair_sel=1 -> next cycle: IDLE, all outputs 0, no result_valid; a late argmax_done rising edge is ignored.
- NPAIRS=1 -> only pair_sel=0 runs; delay1=delay2=0; result_valid 2 cycles after the argmax_done edge.
- With XCORR_SCHED_WATCHDOG_EN, TIMEOUT=20, xcorr_done never asserted -> timeout_err=1 at cycle 20 of XCORR; state IDLE; no result_valid; timeout_err stays 1 until n_rst.

Source files
------------

// File: rtl/xcorr_scheduler.sv
// xcorr_scheduler: frame-level sequencer for the microphone delay-estimation
// pipeline. Launches ADC captures, waits for the ping-pong swap, then runs
// xcorr followed by argmax for each pair (ch0, ch(k+1)), k = 0..NPAIRS-1. The
// per-pair peak indices are latched and published with a one-cycle result_valid.
// Optional feature: define XCORR_SCHED_WATCHDOG_EN to add a per-wait-state
// watchdog (TIMEOUT cycles) that raises a sticky timeout_err and returns to IDLE.
module xcorr_scheduler #(
    parameter int IDX_W  = 9,
    parameter int NPAIRS = 3,
    parameter int CNT_W  = 16
`ifdef XCORR_SCHED_WATCHDOG_EN
    ,
    parameter int TIMEOUT = 65535
`endif
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             enable,
    output logic             sample_start,
    input  logic             sample_done,
    input  logic             buf_ready,
    output logic [1:0]       pair_sel,
    output logic             xcorr_start,
    input  logic             xcorr_done,
    output logic             argmax_start,
    input  logic             argmax_done,
    input  logic [IDX_W-1:0] argmax_index,
    output logic [IDX_W-1:0] delay0,
    output logic [IDX_W-1:0] delay1,
    output logic [IDX_W-1:0] delay2,
    output logic             result_valid,
    output logic [CNT_W-1:0] frame_count,
    output logic             busy,
    output logic             timeout_err
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FILL    = 3'd1,
        S_SWAP    = 3'd2,
        S_XCORR   = 3'd3,
        S_ARGMAX  = 3'd4,
        S_PUBLISH = 3'd5
    } state_t;

    localparam logic [1:0] LAST_PAIR = 2'(NPAIRS - 1);

    state_t           state_d, state_q;
    logic [1:0]       pair_sel_d, pair_sel_q;
    logic             inflight_d, inflight_q;
    // A capture completion seen before FILL is re-entered.
    logic             seen_d, seen_q;
    logic             sample_start_d, sample_start_q;
    logic             xcorr_start_d, xcorr_start_q;
    logic             argmax_start_d, argmax_start_q;
    logic             result_valid_d, result_valid_q;
    logic [IDX_W-1:0] delay0_d, delay0_q;
    logic [IDX_W-1:0] delay1_d, delay1_q;
    logic [IDX_W-1:0] delay2_d, delay2_q;
    logic [CNT_W-1:0] frame_count_d, frame_count_q;
    logic             busy_d, busy_q;
    logic             timeout_err_d, timeout_err_q;
    logic             sample_done_q, xcorr_done_q, argmax_done_q;
    logic             sample_rise_s, xcorr_rise_s, argmax_rise_s;
    logic             launch_s;

`ifdef XCORR_SCHED_WATCHDOG_EN
    localparam int              WD_W     = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT - 1);
    logic [WD_W-1:0] wait_cnt_d, wait_cnt_q;
    logic            wait_state_s;
`endif

    // Only a fresh low-to-high transition completes a phase; stale levels are ignored.
    assign sample_rise_s = sample_done & ~sample_done_q;
    assign xcorr_rise_s  = xcorr_done  & ~xcorr_done_q;
    assign argmax_rise_s = argmax_done & ~argmax_done_q;

    // Next-state and next-output computation for the frame sequencer.
    always_comb begin
        state_d        = state_q;
        pair_sel_d     = pair_sel_q;
        inflight_d     = inflight_q;
        seen_d         = seen_q | (sample_rise_s & inflight_q);
        sample_start_d = 1'b0;
        xcorr_start_d  = 1'b0;
        argmax_start_d = 1'b0;
        result_valid_d = 1'b0;
        delay0_d       = delay0_q;
        delay1_d       = delay1_q;
        delay2_d       = delay2_q;
        frame_count_d  = frame_count_q;
        timeout_err_d  = timeout_err_q;
        launch_s       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (enable) begin
                    sample_start_d = 1'b1;
                    inflight_d     = 1'b1;
                    seen_d         = 1'b0;
                    state_d        = S_FILL;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_FILL: begin
                // When the buffers are already swapped the SWAP wait collapses to zero cycles.
                if (seen_q || sample_rise_s) begin
                    if (buf_ready) begin
                        launch_s = 1'b1;
                    end else begin
                        seen_d  = 1'b0;
                        state_d = S_SWAP;
                    end
                end else begin
                    state_d = S_FILL;
                end
            end
            S_SWAP: begin
                if (buf_ready) begin
                    launch_s = 1'b1;
                end else begin
                    state_d = S_SWAP;
                end
            end
            S_XCORR: begin
                if (xcorr_rise_s) begin
                    argmax_start_d = 1'b1;
                    state_d        = S_ARGMAX;
                end else begin
                    state_d = S_XCORR;
                end
            end
            S_ARGMAX: begin
                if (argmax_rise_s) begin
                    case (pair_sel_q)
                        2'd0:    delay0_d = argmax_index;
                        2'd1:    delay1_d = argmax_index;
                        default: delay2_d = argmax_index;
                    endcase
                    if (pair_sel_q == LAST_PAIR) begin
                        state_d = S_PUBLISH;
                    end else begin
                        pair_sel_d    = pair_sel_q + 2'd1;
                        xcorr_start_d = 1'b1;
                        state_d       = S_XCORR;
                    end
                end else begin
                    state_d = S_ARGMAX;
                end
            end
            S_PUBLISH: begin
                result_valid_d = 1'b1;
                frame_count_d  = frame_count_q + CNT_W'(1);
                if (inflight_q) begin
                    state_d = S_FILL;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Start processing the swapped frame; overlap the next capture if still enabled.
        if (launch_s) begin
            pair_sel_d    = 2'd0;
            xcorr_start_d = 1'b1;
            seen_d        = 1'b0;
            state_d       = S_XCORR;
            if (enable) begin
                sample_start_d = 1'b1;
                inflight_d     = 1'b1;
            end else begin
                inflight_d = 1'b0;
            end
        end else begin
            launch_s = 1'b0;
        end

`ifdef XCORR_SCHED_WATCHDOG_EN
        wait_state_s = (state_q == S_FILL) || (state_q == S_SWAP) ||
                       (state_q == S_XCORR) || (state_q == S_ARGMAX);
        if (!wait_state_s || (state_d != state_q)) begin
            wait_cnt_d = '0;
        end else if (wait_cnt_q == WD_LIMIT) begin
            // Abandon the frame: no publish, capture tracking cleared.
            wait_cnt_d     = '0;
            timeout_err_d  = 1'b1;
            inflight_d     = 1'b0;
            seen_d         = 1'b0;
            pair_sel_d     = 2'd0;
            sample_start_d = 1'b0;
            xcorr_start_d  = 1'b0;
            argmax_start_d = 1'b0;
            state_d        = S_IDLE;
        end else begin
            wait_cnt_d = wait_cnt_q + WD_W'(1);
        end
`else
        timeout_err_d = 1'b0;
`endif

        busy_d = (state_d != S_IDLE);
    end

    // State, registered outputs and done-edge history.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q        <= S_IDLE;
            pair_sel_q     <= 2'd0;
            inflight_q     <= 1'b0;
            seen_q         <= 1'b0;
            sample_start_q <= 1'b0;
            xcorr_start_q  <= 1'b0;
            argmax_start_q <= 1'b0;
            result_valid_q <= 1'b0;
            delay0_q       <= '0;
            delay1_q       <= '0;
            delay2_q       <= '0;
            frame_count_q  <= '0;
            busy_q         <= 1'b0;
            timeout_err_q  <= 1'b0;
            sample_done_q  <= 1'b0;
            xcorr_done_q   <= 1'b0;
            argmax_done_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            pair_sel_q     <= pair_sel_d;
            inflight_q     <= inflight_d;
            seen_q         <= seen_d;
            sample_start_q <= sample_start_d;
            xcorr_start_q  <= xcorr_start_d;
            argmax_start_q <= argmax_start_d;
            result_valid_q <= result_valid_d;
            delay0_q       <= delay0_d;
            delay1_q       <= delay1_d;
            delay2_q       <= delay2_d;
            frame_count_q  <= frame_count_d;
            busy_q         <= busy_d;
            timeout_err_q  <= timeout_err_d;
            sample_done_q  <= sample_done;
            xcorr_done_q   <= xcorr_done;
            argmax_done_q  <= argmax_done;
        end
    end

`ifdef XCORR_SCHED_WATCHDOG_EN
    // Per-state wait counter for the watchdog.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end
`endif

    assign sample_start = sample_start_q;
    assign pair_sel     = pair_sel_q;
    assign xcorr_start  = xcorr_start_q;
    assign argmax_start = argmax_start_q;
    assign delay0       = delay0_q;
    assign delay1       = delay1_q;
    assign delay2       = delay2_q;
    assign result_valid = result_valid_q;
    assign frame_count  = frame_count_q;
    assign busy         = busy_q;
    assign timeout_err  = timeout_err_q;

endmodule

// File: tb/tb_xcorr_scheduler.sv
// Directed testbench for xcorr_scheduler: single frame, continuous run,
// stale sample_done / late buf_ready, mid-frame reset, NPAIRS=1 instance and,
// when XCORR_SCHED_WATCHDOG_EN is defined, a TIMEOUT=20 watchdog instance.
module tb_xcorr_scheduler;
    localparam int IDX_W = 9;
    localparam int CNT_W = 16;

    logic             clk, n_rst, enable, enable1, sample_done, buf_ready;
    logic             xcorr_done, argmax_done;
    logic [IDX_W-1:0] argmax_index;

    logic             sample_start, xcorr_start, argmax_start, result_valid, busy, timeout_err;
    logic [1:0]       pair_sel;
    logic [IDX_W-1:0] delay0, delay1, delay2;
    logic [CNT_W-1:0] frame_count;

    logic             s1_sample_start, s1_xcorr_start, s1_argmax_start, s1_result_valid, s1_busy, s1_timeout_err;
    logic [1:0]       s1_pair_sel;
    logic [IDX_W-1:0] s1_delay0, s1_delay1, s1_delay2;
    logic [CNT_W-1:0] s1_frame_count;

    int n_assert = 0;
    int n_fail   = 0;

    xcorr_scheduler #(.IDX_W(IDX_W), .NPAIRS(3), .CNT_W(CNT_W)) u_dut (
        .clk(clk), .n_rst(n_rst), .enable(enable), .sample_start(sample_start),
        .sample_done(sample_done), .buf_ready(buf_ready), .pair_sel(pair_sel),
        .xcorr_start(xcorr_start), .xcorr_done(xcorr_done), .argmax_start(argmax_start),
        .argmax_done(argmax_done), .argmax_index(argmax_index), .delay0(delay0),
        .delay1(delay1), .delay2(delay2), .result_valid(result_valid),
        .frame_count(frame_count), .busy(busy), .timeout_err(timeout_err)
    );

    xcorr_scheduler #(.IDX_W(IDX_W), .NPAIRS(1), .CNT_W(CNT_W)) u_dut1 (
        .clk(clk), .n_rst(n_rst), .enable(enable1), .sample_start(s1_sample_start),
        .sample_done(sample_done), .buf_ready(buf_ready), .pair_sel(s1_pair_sel),
        .xcorr_start(s1_xcorr_start), .xcorr_done(xcorr_done), .argmax_start(s1_argmax_start),
        .argmax_done(argmax_done), .argmax_index(argmax_index), .delay0(s1_delay0),
        .delay1(s1_delay1), .delay2(s1_delay2), .result_valid(s1_result_valid),
        .frame_count(s1_frame_count), .busy(s1_busy), .timeout_err(s1_timeout_err)
    );

`ifdef XCORR_SCHED_WATCHDOG_EN
    logic             enable_wd;
    logic             w_sample_start, w_xcorr_start, w_argmax_start, w_result_valid, w_busy, w_timeout_err;
    logic [1:0]       w_pair_sel;
    logic [IDX_W-1:0] w_delay0, w_delay1, w_delay2;
    logic [CNT_W-1:0] w_frame_count;

    xcorr_scheduler #(.IDX_W(IDX_W), .NPAIRS(3), .CNT_W(CNT_W), .TIMEOUT(20)) u_wd (
        .clk(clk), .n_rst(n_rst), .enable(enable_wd), .sample_start(w_sample_start),
        .sample_done(sample_done), .buf_ready(buf_ready), .pair_sel(w_pair_sel),
        .xcorr_start(w_xcorr_start), .xcorr_done(xcorr_done), .argmax_start(w_argmax_start),
        .argmax_done(argmax_done), .argmax_index(argmax_index), .delay0(w_delay0),
        .delay1(w_delay1), .delay2(w_delay2), .result_valid(w_result_valid),
        .frame_count(w_frame_count), .busy(w_busy), .timeout_err(w_timeout_err)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; outputs are sampled and inputs changed 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [IDX_W-1:0] delay_of(input int p);
        if (p == 0) return delay0;
        else if (p == 1) return delay1;
        else return delay2;
    endfunction

    // Run one xcorr/argmax pair on u_dut; entry point is the cycle xcorr_start is high.
    task automatic do_pair(input int p, input logic [IDX_W-1:0] idx, input int lag, input bit last);
        xcorr_done  = 1'b0;
        argmax_done = 1'b0;
        tick();
        check("xstart_one_cycle", 32'(xcorr_start), 32'd0);
        check("pair_sel_xcorr", 32'(pair_sel), 32'(p));
        repeat (lag) tick();
        xcorr_done = 1'b1;
        tick();
        check("argmax_start", 32'(argmax_start), 32'd1);
        check("xstart_low_in_argmax", 32'(xcorr_start), 32'd0);
        check("pair_sel_argmax", 32'(pair_sel), 32'(p));
        tick();
        check("astart_one_cycle", 32'(argmax_start), 32'd0);
        repeat (lag) tick();
        argmax_index = idx;
        argmax_done  = 1'b1;
        tick();
        check("delay_latched", 32'(delay_of(p)), 32'(idx));
        if (last) begin
            check("no_rv_in_publish", 32'(result_valid), 32'd0);
            check("no_xstart_last", 32'(xcorr_start), 32'd0);
        end else begin
            check("next_xstart", 32'(xcorr_start), 32'd1);
            check("next_pair_sel", 32'(pair_sel), 32'(p + 1));
        end
    endtask

    task automatic do_reset();
        n_rst       = 1'b0;
        enable      = 1'b0;
        sample_done = 1'b0;
        buf_ready   = 1'b0;
        xcorr_done  = 1'b0;
        argmax_done = 1'b0;
        tick();
        n_rst = 1'b1;
    endtask

    initial begin
        int stale_hits;
        enable1      = 1'b0;
        argmax_index = '0;
`ifdef XCORR_SCHED_WATCHDOG_EN
        enable_wd = 1'b0;
`endif
        // Reset state
        do_reset();
        n_rst = 1'b0;
        tick();
        check("rst_sample_start", 32'(sample_start), 32'd0);
        check("rst_pair_sel", 32'(pair_sel), 32'd0);
        check("rst_delay0", 32'(delay0), 32'd0);
        check("rst_frame_count", 32'(frame_count), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_result_valid", 32'(result_valid), 32'd0);
        check("rst_timeout_err", 32'(timeout_err), 32'd0);
        n_rst = 1'b1;
        tick();

        // Test 1: single frame, enable pulsed for one cycle
        enable = 1'b1;
        tick();
        check("t1_sample_start", 32'(sample_start), 32'd1);
        check("t1_busy", 32'(busy), 32'd1);
        enable = 1'b0;
        tick();
        check("t1_sstart_one_cycle", 32'(sample_start), 32'd0);
        sample_done = 1'b1;
        tick();
        check("t1_wait_buf_ready", 32'(xcorr_start), 32'd0);
        buf_ready = 1'b1;
        tick();
        check("t1_xcorr_start", 32'(xcorr_start), 32'd1);
        check("t1_no_second_capture", 32'(sample_start), 32'd0);
        do_pair(0, 9'd100, 1, 1'b0);
        do_pair(1, 9'd255, 2, 1'b0);
        do_pair(2, 9'd3, 1, 1'b1);
        tick();
        check("t1_result_valid", 32'(result_valid), 32'd1);
        check("t1_frame_count", 32'(frame_count), 32'd1);
        tick();
        check("t1_rv_one_cycle", 32'(result_valid), 32'd0);
        check("t1_idle", 32'(busy), 32'd0);
        check("t1_delay0", 32'(delay0), 32'd100);
        check("t1_delay1", 32'(delay1), 32'd255);
        check("t1_delay2", 32'(delay2), 32'd3);

        // Test 2: continuous run of four frames with overlapped captures
        do_reset();
        enable = 1'b1;
        tick();
        check("t2_first_capture", 32'(sample_start), 32'd1);
        sample_done = 1'b1;
        buf_ready   = 1'b1;
        tick();
        for (int f = 0; f < 4; f++) begin
            check("t2_capture_at_swap", 32'(sample_start), 32'(f < 3));
            check("t2_launch", 32'(xcorr_start), 32'd1);
            check("t2_pair_sel0", 32'(pair_sel), 32'd0);
            if (f == 2) enable = 1'b0;
            sample_done = 1'b0;
            do_pair(0, 9'(f * 37 + 5), 1, 1'b0);
            if (f < 3) sample_done = 1'b1;
            do_pair(1, 9'(f * 37 + 105), 1, 1'b0);
            do_pair(2, 9'(f * 37 + 205), 1, 1'b1);
            tick();
            check("t2_result_valid", 32'(result_valid), 32'd1);
            check("t2_frame_count", 32'(frame_count), 32'(f + 1));
            tick();
            if (f == 3) begin
                check("t2_end_rv_low", 32'(result_valid), 32'd0);
                check("t2_end_idle", 32'(busy), 32'd0);
            end
        end

        // Test 3: stale sample_done level, then buf_ready late by 50 cycles
        sample_done = 1'b1;
        tick();
        enable = 1'b1;
        tick();
        check("t3_sample_start", 32'(sample_start), 32'd1);
        enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t3_stale_ignored", 32'(xcorr_start), 32'd0);
        end
        buf_ready   = 1'b0;
        sample_done = 1'b0;
        tick();
        sample_done = 1'b1;
        tick();
        stale_hits = 0;
        for (int i = 0; i < 50; i++) begin
            if (xcorr_start !== 1'b0) stale_hits++;
            tick();
        end
        check("t3_no_xstart_in_swap", 32'(stale_hits), 32'd0);
        buf_ready = 1'b1;
        tick();
        check("t3_xstart_after_ready", 32'(xcorr_start), 32'd1);
        check("t3_no_capture", 32'(sample_start), 32'd0);
        do_pair(0, 9'd7, 3, 1'b0);
        do_pair(1, 9'd0, 1, 1'b0);
        do_pair(2, 9'd511, 2, 1'b1);
        tick();
        check("t3_result_valid", 32'(result_valid), 32'd1);
        check("t3_frame_count", 32'(frame_count), 32'd5);
        tick();
        check("t3_idle", 32'(busy), 32'd0);

        // Test 4: reset while in ARGMAX for pair 1
        enable = 1'b1;
        tick();
        check("t4_sample_start", 32'(sample_start), 32'd1);
        enable      = 1'b0;
        sample_done = 1'b0;
        tick();
        sample_done = 1'b1;
        tick();
        check("t4_launch", 32'(xcorr_start), 32'd1);
        do_pair(0, 9'd42, 1, 1'b0);
        xcorr_done = 1'b0;
        tick();
        xcorr_done = 1'b1;
        tick();
        check("t4_argmax_pair1", 32'(pair_sel), 32'd1);
        argmax_done = 1'b0;
        tick();
        n_rst = 1'b0;
        tick();
        n_rst = 1'b1;
        check("t4_rst_busy", 32'(busy), 32'd0);
        check("t4_rst_pair_sel", 32'(pair_sel), 32'd0);
        check("t4_rst_delay0", 32'(delay0), 32'd0);
        check("t4_rst_frame_count", 32'(frame_count), 32'd0);
        check("t4_rst_pulses", 32'({sample_start, xcorr_start, argmax_start, result_valid}), 32'd0);
        check("t4_rst_timeout_err", 32'(timeout_err), 32'd0);
        argmax_index = 9'd99;
        argmax_done  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t4_late_done_rv", 32'(result_valid), 32'd0);
            check("t4_late_done_delay1", 32'(delay1), 32'd0);
            check("t4_late_done_idle", 32'(busy), 32'd0);
        end

        // Test 5: NPAIRS=1 instance
        sample_done = 1'b0;
        xcorr_done  = 1'b0;
        argmax_done = 1'b0;
        buf_ready   = 1'b1;
        enable1     = 1'b1;
        tick();
        check("t5_sample_start", 32'(s1_sample_start), 32'd1);
        enable1     = 1'b0;
        sample_done = 1'b1;
        tick();
        check("t5_launch", 32'(s1_xcorr_start), 32'd1);
        check("t5_pair_sel", 32'(s1_pair_sel), 32'd0);
        tick();
        xcorr_done = 1'b1;
        tick();
        check("t5_argmax_start", 32'(s1_argmax_start), 32'd1);
        tick();
        argmax_index = 9'd321;
        argmax_done  = 1'b1;
        tick();
        check("t5_no_rv_yet", 32'(s1_result_valid), 32'd0);
        check("t5_no_next_pair", 32'(s1_xcorr_start), 32'd0);
        check("t5_delay0", 32'(s1_delay0), 32'd321);
        tick();
        check("t5_result_valid", 32'(s1_result_valid), 32'd1);
        check("t5_frame_count", 32'(s1_frame_count), 32'd1);
        check("t5_delay1", 32'(s1_delay1), 32'd0);
        check("t5_delay2", 32'(s1_delay2), 32'd0);
        tick();
        check("t5_rv_one_cycle", 32'(s1_result_valid), 32'd0);
        check("t5_idle", 32'(s1_busy), 32'd0);

`ifdef XCORR_SCHED_WATCHDOG_EN
        // Test 6: watchdog with TIMEOUT=20, xcorr_done never rises
        sample_done = 1'b0;
        xcorr_done  = 1'b0;
        buf_ready   = 1'b1;
        enable_wd   = 1'b1;
        tick();
        check("t6_sample_start", 32'(w_sample_start), 32'd1);
        enable_wd   = 1'b0;
        sample_done = 1'b1;
        tick();
        check("t6_launch", 32'(w_xcorr_start), 32'd1);
        repeat (19) tick();
        check("t6_no_err_before_limit", 32'(w_timeout_err), 32'd0);
        check("t6_busy_before_limit", 32'(w_busy), 32'd1);
        tick();
        check("t6_timeout_err", 32'(w_timeout_err), 32'd1);
        check("t6_idle", 32'(w_busy), 32'd0);
        check("t6_no_rv", 32'(w_result_valid), 32'd0);
        repeat (5) tick();
        check("t6_sticky", 32'(w_timeout_err), 32'd1);
        check("t6_still_no_rv", 32'(w_result_valid), 32'd0);
        n_rst = 1'b0;
        tick();
        n_rst = 1'b1;
        check("t6_cleared_by_reset", 32'(w_timeout_err), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
